// File: rtl/stg_if.sv
// Instruction-fetch stage: owns the fetch PC, issues imem word reads under a credit limit,
// buffers in-order responses with their PC tags and presents one registered instruction per cycle.
module stg_if #(
  parameter int                   SIZE_ADDR = 8,
  parameter int                   SIZE_DATA = 32,
  parameter logic [SIZE_ADDR-1:0] RESET_PC  = '0,
  parameter int                   DEPTH     = 2,
  parameter int                   MAX_OUT   = 2
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst_n,
  input  logic                 iw_stall,
  input  logic                 iw_flush,
  input  logic                 iw_redirect,
  input  logic [SIZE_ADDR-1:0] iw_redirect_pc,
  output logic                 ow_imem_req,
  output logic [SIZE_ADDR-1:0] ow_imem_addr,
  input  logic                 iw_imem_gnt,
  input  logic                 iw_imem_rvalid,
  input  logic [SIZE_DATA-1:0] iw_imem_rdata,
  output logic                 ow_valid,
  output logic [SIZE_ADDR-1:0] ow_pc,
  output logic [SIZE_DATA-1:0] ow_instr
);

  localparam int CW  = $clog2(MAX_OUT + DEPTH + 1) + 1;
  localparam int TQ  = MAX_OUT;
  localparam int TIW = (TQ > 1) ? $clog2(TQ) : 1;
  localparam int FIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SIZE_ADDR-1:0] pc;
  logic [CW-1:0]        live;
  logic [CW-1:0]        drop;
  logic [CW-1:0]        fifo_cnt;
  logic [SIZE_ADDR-1:0] tag_q      [TQ];
  logic [SIZE_ADDR-1:0] fifo_pc    [DEPTH];
  logic [SIZE_DATA-1:0] fifo_instr [DEPTH];

  logic          grant;
  logic          resp_drop;
  logic          resp_live;
  logic          resp_any;
  logic          take;
  logic          fifo_pop;
  logic          bypass;
  logic          fifo_push;
  logic [CW-1:0] tag_idx;
  logic [CW-1:0] fifo_idx;

  // Credit rule: live requests always have a FIFO slot reserved, so a push never overflows.
  assign ow_imem_req  = iw_rst_n && !iw_redirect
                        && ((live + drop) < CW'(MAX_OUT))
                        && ((live + fifo_cnt) < CW'(DEPTH));
  assign ow_imem_addr = pc;
  assign grant        = ow_imem_req && iw_imem_gnt;

  assign resp_drop = iw_imem_rvalid && (drop != '0);
  assign resp_live = iw_imem_rvalid && (drop == '0) && (live != '0);
  assign resp_any  = iw_imem_rvalid && ((drop != '0) || (live != '0));

  assign take      = !iw_redirect && !iw_flush && !iw_stall;
  assign fifo_pop  = take && (fifo_cnt != '0);
  assign bypass    = take && (fifo_cnt == '0) && resp_live;
  assign fifo_push = resp_live && !bypass && !iw_redirect;

  assign tag_idx  = live - CW'(resp_live);
  assign fifo_idx = fifo_cnt - CW'(fifo_pop);

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      pc       <= RESET_PC;
      live     <= '0;
      drop     <= '0;
      fifo_cnt <= '0;
    end else if (iw_redirect) begin
      // Everything still in flight, including a response landing now, becomes a drop.
      pc       <= iw_redirect_pc;
      drop     <= drop + live - CW'(resp_any);
      live     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (grant)
        pc <= pc + SIZE_ADDR'(1);
      live     <= live + CW'(grant) - CW'(resp_live);
      drop     <= drop - CW'(resp_drop);
      fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge iw_clk) begin
    if (resp_live) begin
      for (int i = 0; i < TQ - 1; i++)
        tag_q[i] <= tag_q[i+1];
    end
    if (grant)
      tag_q[TIW'(tag_idx)] <= pc;
  end

  always_ff @(posedge iw_clk) begin
    if (fifo_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fifo_pc[i]    <= fifo_pc[i+1];
        fifo_instr[i] <= fifo_instr[i+1];
      end
    end
    if (fifo_push) begin
      fifo_pc[FIW'(fifo_idx)]    <= tag_q[0];
      fifo_instr[FIW'(fifo_idx)] <= iw_imem_rdata;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n || iw_redirect || iw_flush) begin
      ow_valid <= 1'b0;
      ow_pc    <= '0;
      ow_instr <= '0;
    end else if (iw_stall) begin
      ow_valid <= ow_valid;
      ow_pc    <= ow_pc;
      ow_instr <= ow_instr;
    end else if (fifo_pop) begin
      ow_valid <= 1'b1;
      ow_pc    <= fifo_pc[0];
      ow_instr <= fifo_instr[0];
    end else if (bypass) begin
      ow_valid <= 1'b1;
      ow_pc    <= tag_q[0];
      ow_instr <= iw_imem_rdata;
    end else begin
      ow_valid <= 1'b0;
      ow_pc    <= '0;
      ow_instr <= '0;
    end
  end

endmodule

// File: tb/tb_stg_if.sv
// Directed bench for stg_if with a behavioural in-order instruction memory (rdata = 0x100 + addr)
// whose response latency is set per scenario.
module tb_stg_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid;
  logic [7:0]  pc;
  logic [31:0] instr;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [7:0] addr;
  } mreq_t;
  mreq_t mq[$];

  stg_if #(
    .SIZE_ADDR(8),
    .SIZE_DATA(32),
    .RESET_PC(8'h00),
    .DEPTH(2),
    .MAX_OUT(2)
  ) dut (
    .iw_clk(clk),
    .iw_rst_n(rst_n),
    .iw_stall(stall),
    .iw_flush(flush),
    .iw_redirect(redirect),
    .iw_redirect_pc(redirect_pc),
    .ow_imem_req(imem_req),
    .ow_imem_addr(imem_addr),
    .iw_imem_gnt(imem_gnt),
    .iw_imem_rvalid(imem_rvalid),
    .iw_imem_rdata(imem_rdata),
    .ow_valid(valid),
    .ow_pc(pc),
    .ow_instr(instr)
  );

  always #5 clk = ~clk;

  // Grants are recorded from pre-edge values; responses are presented on the following negedges.
  always @(posedge clk) begin
    mreq_t m;
    if (!rst_n) begin
      mq.delete();
    end else if (imem_req && imem_gnt) begin
      m.due  = cyc + lat;
      m.addr = imem_addr;
      mq.push_back(m);
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h100 + {24'h0, mq[0].addr};
      mq.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  task automatic do_reset(input int l);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = 8'h00; imem_gnt = 1'b1; lat = l;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    imem_gnt = 1'b1; lat = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== 41'h0) begin
      errors++;
      $display("[TB] FAIL reset_out got %0b/%h/%h want 0/00/00000000", valid, pc, instr);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req got %0b want 0", imem_req);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_release_req got %0b/%h want 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_first_bubble got %0b want 0", valid);
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  ep;
      logic [31:0] ei;
      ep = 8'(i);
      ei = 32'h100 + 32'(i);
      @(negedge clk);
      checks++;
      if ({valid, pc, instr} !== {1'b1, ep, ei}) begin
        errors++;
        $display("[TB] FAIL stream_%0d got %0b/%h/%h want 1/%h/%h", i, valid, pc, instr, ep, ei);
      end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_first_req got %0b want 1", imem_req);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({valid, pc, instr} !== {1'b1, 8'h07, 32'h107}) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d got %0b/%h/%h want 1/07/00000107", c, valid, pc, instr);
      end
      checks++;
      if (imem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_credit_%0d got req %0b want 0", c, imem_req);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0]  ep;
      logic [31:0] ei;
      ep = 8'(8 + i);
      ei = 32'h108 + 32'(i);
      @(negedge clk);
      checks++;
      if ({valid, pc, instr} !== {1'b1, ep, ei}) begin
        errors++;
        $display("[TB] FAIL stall_resume_%0d got %0b/%h/%h want 1/%h/%h", i, valid, pc, instr, ep, ei);
      end
    end
  endtask

  task automatic test_redirect;
    do_reset(3);
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_req got %0b want 0", imem_req);
    end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b0, 8'h40}) begin
      errors++;
      $display("[TB] FAIL redirect_after got v%0b req%0b addr %h want v0 req0 addr 40", valid, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h40}) begin
      errors++;
      $display("[TB] FAIL redirect_reissue got v%0b req%0b addr %h want v0 req1 addr 40", valid, imem_req, imem_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL redirect_drop_%0d got valid %0b pc %h want valid 0", c, valid, pc);
      end
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h40, 32'h140}) begin
      errors++;
      $display("[TB] FAIL redirect_first got %0b/%h/%h want 1/40/00000140", valid, pc, instr);
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h41, 32'h141}) begin
      errors++;
      $display("[TB] FAIL redirect_second got %0b/%h/%h want 1/41/00000141", valid, pc, instr);
    end
  endtask

  task automatic test_flush;
    do_reset(1);
    for (int c = 0; c < 5; c++)
      @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h03, 32'h103}) begin
      errors++;
      $display("[TB] FAIL flush_pre got %0b/%h/%h want 1/03/00000103", valid, pc, instr);
    end
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== 41'h0) begin
      errors++;
      $display("[TB] FAIL flush_bubble got %0b/%h/%h want 0/00/00000000", valid, pc, instr);
    end
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0]  ep;
      logic [31:0] ei;
      ep = 8'(4 + i);
      ei = 32'h104 + 32'(i);
      @(negedge clk);
      checks++;
      if ({valid, pc, instr} !== {1'b1, ep, ei}) begin
        errors++;
        $display("[TB] FAIL flush_resume_%0d got %0b/%h/%h want 1/%h/%h", i, valid, pc, instr, ep, ei);
      end
    end
    flush = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== 41'h0) begin
      errors++;
      $display("[TB] FAIL flush_over_stall got %0b/%h/%h want 0/00/00000000", valid, pc, instr);
    end
    flush = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h08, 32'h108}) begin
      errors++;
      $display("[TB] FAIL flush_stall_next got %0b/%h/%h want 1/08/00000108", valid, pc, instr);
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h09, 32'h109}) begin
      errors++;
      $display("[TB] FAIL flush_stall_next2 got %0b/%h/%h want 1/09/00000109", valid, pc, instr);
    end
  endtask

  task automatic test_no_grant;
    do_reset(1);
    for (int c = 0; c < 4; c++)
      @(negedge clk);
    imem_gnt = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h04}) begin
      errors++;
      $display("[TB] FAIL nogrant_start got %0b/%h want 1/04", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr, imem_req, imem_addr} !== {1'b1, 8'h03, 32'h103, 1'b1, 8'h04}) begin
      errors++;
      $display("[TB] FAIL nogrant_drain got %0b/%h/%h req %0b addr %h want 1/03/00000103 req 1 addr 04",
               valid, pc, instr, imem_req, imem_addr);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({valid, pc, instr, imem_req, imem_addr} !== {1'b0, 8'h00, 32'h0, 1'b1, 8'h04}) begin
        errors++;
        $display("[TB] FAIL nogrant_hold_%0d got %0b/%h/%h req %0b addr %h want 0/00/00000000 req 1 addr 04",
                 c, valid, pc, instr, imem_req, imem_addr);
      end
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nogrant_latency got %0b want 0", valid);
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h04, 32'h104}) begin
      errors++;
      $display("[TB] FAIL nogrant_resume got %0b/%h/%h want 1/04/00000104", valid, pc, instr);
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h05, 32'h105}) begin
      errors++;
      $display("[TB] FAIL nogrant_resume2 got %0b/%h/%h want 1/05/00000105", valid, pc, instr);
    end
  endtask

  task automatic test_wrap_reset;
    do_reset(1);
    redirect = 1'b1;
    redirect_pc = 8'hFF;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL wrap_top got %0b/%h want 1/ff", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL wrap_zero got %0b/%h want 1/00", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'hFF, 32'h1FF}) begin
      errors++;
      $display("[TB] FAIL wrap_out_ff got %0b/%h/%h want 1/ff/000001ff", valid, pc, instr);
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h00, 32'h100}) begin
      errors++;
      $display("[TB] FAIL wrap_out_00 got %0b/%h/%h want 1/00/00000100", valid, pc, instr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid, pc, instr, imem_req} !== 42'h0) begin
      errors++;
      $display("[TB] FAIL midreset_out got %0b/%h/%h req %0b want all 0", valid, pc, instr, imem_req);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL midreset_pc got %0b/%h want 1/00", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_bubble got %0b want 0", valid);
    end
    @(negedge clk);
    checks++;
    if ({valid, pc, instr} !== {1'b1, 8'h00, 32'h100}) begin
      errors++;
      $display("[TB] FAIL midreset_first got %0b/%h/%h want 1/00/00000100", valid, pc, instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_flush();
    test_no_grant();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
